// File: rtl/snoop_bus_arbiter.sv
// Two-cache snooping bus arbiter: grants one cache at a time, snoops the peer,
// and serves the request by cache-to-cache transfer, memory read or writeback.
module snoop_bus_arbiter (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  logic [1:0][31:0] daddr,
    input  logic [1:0][31:0] dstore,
    input  logic [1:0]       ccwrite,
    output logic [1:0]       dwait,
    output logic [1:0][31:0] dload,
    output logic [1:0]       ccwait,
    output logic [1:0]       ccinv,
    output logic [1:0][31:0] ccsnoopaddr,
    output logic             mem_dREN,
    output logic             mem_dWEN,
    output logic [31:0]      mem_daddr,
    output logic [31:0]      mem_dstore,
    input  logic [31:0]      mem_dload,
    input  logic             mem_dwait
);

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        C2C,
        MEM_READ,
        WRITEBACK
    } state_t;

    state_t state_q, state_d;
    logic   req_q, req_d;
    logic   last_grant_q, last_grant_d;
    logic   grant;
    logic   peer;
    logic   req_live;
    logic [1:0] active;

    assign active   = dREN | dWEN;
    assign peer     = ~req_q;
    assign req_live = active[req_q];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        last_grant_d = last_grant_q;
        grant        = 1'b0;
        dwait        = 2'b11;
        dload        = '0;
        ccwait       = 2'b00;
        ccinv        = 2'b00;
        ccsnoopaddr  = '0;
        mem_dREN     = 1'b0;
        mem_dWEN     = 1'b0;
        mem_daddr    = 32'h0;
        mem_dstore   = 32'h0;

        case (state_q)
            IDLE: begin
                if (|active) begin
                    // On a tie the cache that lost last time wins.
                    grant        = (&active) ? ~last_grant_q : active[1];
                    req_d        = grant;
                    last_grant_d = grant;
                    state_d      = dWEN[grant] ? WRITEBACK : SNOOP;
                end
            end

            SNOOP: begin
                ccwait[peer]      = 1'b1;
                ccsnoopaddr[peer] = daddr[req_q];
                ccinv[peer]       = ccwrite[req_q];
                if (!req_live)
                    state_d = IDLE;
                else if (dWEN[peer])
                    state_d = C2C;
                else
                    state_d = MEM_READ;
            end

            C2C: begin
                // Peer's dirty word goes to the requester and to memory at once;
                // the transfer finishes even if the requester lets go.
                ccwait[peer]      = 1'b1;
                ccsnoopaddr[peer] = daddr[req_q];
                ccinv[peer]       = ccwrite[req_q];
                mem_dWEN          = 1'b1;
                mem_daddr         = daddr[peer];
                mem_dstore        = dstore[peer];
                dload[req_q]      = dstore[peer];
                if (!mem_dwait) begin
                    dwait   = 2'b00;
                    state_d = IDLE;
                end
            end

            MEM_READ: begin
                dload[req_q] = mem_dload;
                if (!req_live) begin
                    state_d = IDLE;
                end else begin
                    mem_dREN     = 1'b1;
                    mem_daddr    = daddr[req_q];
                    dwait[req_q] = mem_dwait;
                    if (!mem_dwait)
                        state_d = IDLE;
                end
            end

            WRITEBACK: begin
                if (!req_live) begin
                    state_d = IDLE;
                end else begin
                    mem_dWEN     = 1'b1;
                    mem_daddr    = daddr[req_q];
                    mem_dstore   = dstore[req_q];
                    dwait[req_q] = mem_dwait;
                    if (!mem_dwait)
                        state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: table of single-cache transactions checked via a
// scoreboard, plus scripted contention, abort and reset-during-transfer cases.
module tb_snoop_bus_arbiter;

    logic             CLK;
    logic             nRST;
    logic [1:0]       dREN, dWEN, ccwrite;
    logic [1:0][31:0] daddr, dstore;
    logic [1:0]       dwait, ccwait, ccinv;
    logic [1:0][31:0] dload, ccsnoopaddr;
    logic             mem_dREN, mem_dWEN, mem_dwait;
    logic [31:0]      mem_daddr, mem_dstore, mem_dload;

    int          total = 0;
    int          bad   = 0;
    int          mem_lat;
    int          mem_cnt;
    logic [31:0] mem_rdata;

    snoop_bus_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite),
        .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_daddr(mem_daddr),
        .mem_dstore(mem_dstore), .mem_dload(mem_dload), .mem_dwait(mem_dwait)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory model: stalls mem_lat cycles after an access starts.
    always @(posedge CLK) begin
        if (mem_dREN || mem_dWEN) mem_cnt <= mem_cnt + 1;
        else                      mem_cnt <= 0;
    end
    assign mem_dwait = (mem_dREN || mem_dWEN) ? (mem_cnt < mem_lat) : 1'b1;
    assign mem_dload = mem_rdata;

    typedef struct {
        int          cache;
        bit          is_wr;
        bit          ccw;
        bit          c2c;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] sdata;
        logic [31:0] mload;
        int          mlat;
        logic [31:0] e_dload;
        logic [31:0] e_maddr;
        logic [31:0] e_mdata;
        bit          e_mwen;
        bit          e_both;
        int          e_lat;
    } vec_t;

    typedef struct {
        int          cache;
        logic [31:0] dload;
        logic [31:0] maddr;
        logic [31:0] mdata;
        bit          mwen;
        bit          both;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];

    function automatic vec_t mk(int c, bit wr, bit ccw, bit c2c,
                                logic [31:0] a, logic [31:0] d, logic [31:0] sd,
                                logic [31:0] ml, int mlat,
                                logic [31:0] ed, logic [31:0] em, logic [31:0] emd,
                                bit emw, bit eb, int el);
        vec_t v;
        v.cache = c; v.is_wr = wr; v.ccw = ccw; v.c2c = c2c;
        v.addr = a; v.data = d; v.sdata = sd; v.mload = ml; v.mlat = mlat;
        v.e_dload = ed; v.e_maddr = em; v.e_mdata = emd;
        v.e_mwen = emw; v.e_both = eb; v.e_lat = el;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic clear_inputs();
        dREN = 2'b00; dWEN = 2'b00; ccwrite = 2'b00;
        daddr = '0; dstore = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dwait"}, {30'h0, dwait}, 32'h3);
        chk({tag, "_dload0"}, dload[0], 32'h0);
        chk({tag, "_dload1"}, dload[1], 32'h0);
        chk({tag, "_ccwait"}, {30'h0, ccwait}, 32'h0);
        chk({tag, "_ccinv"}, {30'h0, ccinv}, 32'h0);
        chk({tag, "_snpaddr"}, ccsnoopaddr[0] | ccsnoopaddr[1], 32'h0);
        chk({tag, "_mem_en"}, {30'h0, mem_dREN, mem_dWEN}, 32'h0);
        chk({tag, "_mem_addr"}, mem_daddr, 32'h0);
        chk({tag, "_mem_data"}, mem_dstore, 32'h0);
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        exp_t        e;
        int          c, o, cyc;
        bit          done, snoop_seen, self_snoop, mem_both;
        logic [31:0] saddr;
        logic        sinv;
        c = v.cache; o = 1 - v.cache;
        e.cache = c; e.dload = v.e_dload; e.maddr = v.e_maddr; e.mdata = v.e_mdata;
        e.mwen = v.e_mwen; e.both = v.e_both; e.lat = v.e_lat;
        sb.push_back(e);

        @(posedge CLK); #1;
        mem_lat = v.mlat; mem_rdata = v.mload;
        if (v.is_wr) dWEN[c] = 1'b1;
        else begin dREN[c] = 1'b1; ccwrite[c] = v.ccw; end
        daddr[c] = v.addr; dstore[c] = v.data;

        cyc = 0; done = 0; snoop_seen = 0; self_snoop = 0; mem_both = 0;
        saddr = 32'h0; sinv = 1'b0;
        while (!done && cyc < 50) begin
            @(negedge CLK);
            if (ccwait[o]) begin
                snoop_seen = 1; saddr = ccsnoopaddr[o]; sinv = ccinv[o];
                if (v.c2c) begin dWEN[o] = 1'b1; dstore[o] = v.sdata; daddr[o] = v.addr; end
            end
            if (ccwait[c]) self_snoop = 1;
            if (mem_dREN && mem_dWEN) mem_both = 1;
            if (!dwait[c]) begin
                e = sb.pop_front();
                chk("done_dload", dload[c], e.dload);
                chk("done_peer_dwait", {31'h0, dwait[o]}, {31'h0, ~e.both});
                chk("done_mem_addr", mem_daddr, e.maddr);
                chk("done_mem_data", mem_dstore, e.mdata);
                chk("done_mem_wen", {31'h0, mem_dWEN}, {31'h0, e.mwen});
                chk("done_mem_ren", {31'h0, mem_dREN}, {31'h0, ~e.mwen});
                chk("done_latency", cyc, e.lat);
                $display("txn %0d cache=%0d addr=%h latency=%0d dload=%h", idx, c, v.addr, cyc, dload[c]);
                done = 1;
            end else begin
                cyc++;
            end
        end
        if (!done) begin
            void'(sb.pop_front());
            chk("txn_timeout", 32'h0, 32'h1);
        end
        chk("snoop_seen", {31'h0, snoop_seen}, {31'h0, ~v.is_wr});
        if (!v.is_wr) begin
            chk("snoop_addr", saddr, v.addr);
            chk("snoop_inv", {31'h0, sinv}, {31'h0, v.ccw});
        end
        chk("self_snoop", {31'h0, self_snoop}, 32'h0);
        chk("mem_both_en", {31'h0, mem_both}, 32'h0);

        @(posedge CLK); #1;
        clear_inputs();
        @(negedge CLK);
        chk("idle_gap_dwait", {30'h0, dwait}, 32'h3);
    endtask

    initial begin : main
        exp_t        e;
        int          n, cyc;
        bit          seen, pulse;
        bit [1:0]    chg;
        logic [31:0] base [2];

        tbl[0] = mk(0, 0, 0, 0, 32'h100, 0, 0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 32'h100, 0, 0, 0, 5);
        tbl[1] = mk(1, 0, 1, 1, 32'h200, 0, 32'h12345678, 0, 0, 32'h12345678, 32'h200, 32'h12345678, 1, 1, 2);
        tbl[2] = mk(0, 1, 0, 0, 32'h300, 32'hA5A5A5A5, 0, 0, 0, 0, 32'h300, 32'hA5A5A5A5, 1, 0, 1);
        tbl[3] = mk(1, 1, 0, 0, 32'h404, 32'h0BADF00D, 0, 0, 2, 0, 32'h404, 32'h0BADF00D, 1, 0, 3);
        tbl[4] = mk(1, 0, 0, 0, 32'h008, 0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 32'h008, 0, 0, 0, 2);
        tbl[5] = mk(0, 0, 1, 1, 32'h010, 0, 32'h55AA55AA, 0, 2, 32'h55AA55AA, 32'h010, 32'h55AA55AA, 1, 1, 4);
        tbl[6] = mk(0, 0, 1, 0, 32'h020, 0, 0, 32'h00000001, 1, 32'h00000001, 32'h020, 0, 0, 0, 3);

        clear_inputs();
        mem_lat = 0; mem_rdata = 32'h0; mem_cnt = 0;
        nRST = 1'b1;
        #2 nRST = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Continuous contention of two writebacks: grants must alternate 0,1,0,1.
        base[0] = 32'h1000; base[1] = 32'h2000;
        for (int k = 0; k < 4; k++) begin
            e.cache = k % 2; e.dload = 0; e.maddr = base[k % 2] + 32'(4 * (k / 2));
            e.mdata = e.maddr ^ 32'hFFFF0000; e.mwen = 1; e.both = 0; e.lat = 0;
            sb.push_back(e);
        end
        @(posedge CLK); #1;
        mem_lat = 0;
        dWEN = 2'b11;
        for (int c = 0; c < 2; c++) begin
            daddr[c] = base[c]; dstore[c] = base[c] ^ 32'hFFFF0000;
        end
        n = 0; cyc = 0;
        while (n < 4 && cyc < 60) begin
            @(negedge CLK);
            cyc++;
            chg = 2'b00;
            for (int c = 0; c < 2; c++) begin
                if (!dwait[c]) begin
                    e = sb.pop_front();
                    chk("rr_cache", c, e.cache);
                    chk("rr_mem_addr", mem_daddr, e.maddr);
                    chk("rr_mem_data", mem_dstore, e.mdata);
                    $display("contention grant %0d cache=%0d addr=%h", n, c, mem_daddr);
                    chg[c] = 1'b1;
                    n++;
                end
            end
            if (chg != 2'b00) begin
                @(posedge CLK); #1;
                for (int c = 0; c < 2; c++) begin
                    if (chg[c]) begin
                        daddr[c] = daddr[c] + 32'h4; dstore[c] = daddr[c] ^ 32'hFFFF0000;
                    end
                end
            end
        end
        chk("rr_count", n, 4);
        sb.delete();
        @(posedge CLK); #1;
        clear_inputs();

        for (int i = 0; i < 7; i++) do_txn(i, tbl[i]);

        // Requester withdraws while its memory read is stalled.
        @(posedge CLK); #1;
        mem_lat = 10; mem_rdata = 32'h0BADBEEF; dREN[0] = 1'b1; daddr[0] = 32'h500;
        seen = 0; pulse = 0; cyc = 0;
        while (!seen && cyc < 10) begin
            @(negedge CLK);
            cyc++;
            if (!dwait[0]) pulse = 1;
            if (mem_dREN) seen = 1;
        end
        chk("abort_reached_read", {31'h0, seen}, 32'h1);
        #1 dREN[0] = 1'b0;
        @(negedge CLK);
        chk("abort_mem_ren", {31'h0, mem_dREN}, 32'h0);
        chk("abort_dwait", {30'h0, dwait}, 32'h3);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (!dwait[0]) pulse = 1;
        end
        chk("abort_no_pulse", {31'h0, pulse}, 32'h0);
        $display("abort sequence done");

        // Reset lands in the middle of a cache-to-cache transfer.
        @(posedge CLK); #1;
        mem_lat = 5; dREN[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h600;
        seen = 0; cyc = 0;
        while (!seen && cyc < 10) begin
            @(negedge CLK);
            cyc++;
            if (ccwait[0]) begin dWEN[0] = 1'b1; dstore[0] = 32'h77777777; daddr[0] = 32'h600; end
            if (mem_dWEN) seen = 1;
        end
        chk("c2c_reached", {31'h0, seen}, 32'h1);
        #1 nRST = 1'b0;
        #1 check_reset_outputs("midreset");
        clear_inputs();
        @(posedge CLK); #1 nRST = 1'b1;
        pulse = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (dwait != 2'b11) pulse = 1;
        end
        chk("post_reset_no_pulse", {31'h0, pulse}, 32'h0);
        $display("reset during transfer sequence done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
